alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 6 +
 rtl/alu_seq.sv | 104 ++++++++++
 tb/tb_alu_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared datapath widths and FSM state type for alu_seq
package alu_seq_pkg;
   localparam int ALU_DW = 8;
   localparam int SEL_W  = 2;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/alu_seq.sv
// alu_seq: registers operands for an external ALU, waits EXEC_CYC cycles, then captures and holds the result
// Optional feature: define ALU_SEQ_ACC_EN to add in_use_acc, which feeds the last result back as operand A
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int EXEC_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ALU_DW-1:0] in_a,
   input  logic [ALU_DW-1:0] in_b,
   input  logic [SEL_W-1:0]  in_sel,
`ifdef ALU_SEQ_ACC_EN
   input  logic              in_use_acc,
`endif
   output logic [ALU_DW-1:0] alu_a,
   output logic [ALU_DW-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [ALU_DW-1:0] alu_out,
   input  logic              alu_v,
   input  logic              alu_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ALU_DW-1:0] res_data,
   output logic              res_v,
   output logic              res_c,
   output logic              busy
);
   localparam int CNT_W = 4;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ALU_DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              v_q, v_d, c_q, c_d;
   logic              acc_sel;
`ifdef ALU_SEQ_ACC_EN
   assign acc_sel = in_use_acc;
`else
   assign acc_sel = 1'b0;
`endif
   // Next state: accept in IDLE, count down in EXEC and capture at zero, hand off in DONE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      res_d   = res_q;
      v_d     = v_q;
      c_d     = c_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = EXEC;
            cnt_d   = CNT_W'(EXEC_CYC - 1);
            a_d     = acc_sel ? res_q : in_a;
            b_d     = in_b;
            sel_d   = in_sel;
         end
         EXEC: if (cnt_q == '0) begin
            state_d = DONE;
            res_d   = alu_out;
            v_d     = alu_v;
            c_d     = alu_c;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         DONE: state_d = res_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         res_q   <= '0;
         v_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         res_q   <= res_d;
         v_q     <= v_d;
         c_q     <= c_d;
      end
   end
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == DONE);
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_sel   = sel_q;
   assign res_data  = res_q;
   assign res_v     = v_q;
   assign res_c     = c_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with EXEC_CYC=1 and EXEC_CYC=3 instances and an adder ALU model
module tb_alu_seq;
   typedef struct {
      logic [7:0] a, b, d;
      logic [1:0] s;
      logic       v, c;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid [2], in_ready [2], res_valid [2], res_ready [2], busy [2];
   logic [7:0] in_a [2], in_b [2], alu_a [2], alu_b [2], alu_out [2], res_data [2];
   logic [1:0] in_sel [2], alu_sel [2];
   logic       alu_v [2], alu_c [2], res_v [2], res_c [2];
`ifdef ALU_SEQ_ACC_EN
   logic       use_acc [2];
`endif
   exp_t       sb [2][$];
   int         ec [2] = '{1, 3};
   int         n_vec = 0, n_err = 0, cyc = 0;
   int         acc_t [2];
   logic [7:0] acc_m [2];
   logic       was_v [2];
   logic [7:0] held_d [2];
   logic       held_v [2], held_c [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign {alu_c[g], alu_out[g]} = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
      assign alu_v[g] = (alu_a[g][7] == alu_b[g][7]) && (alu_out[g][7] != alu_a[g][7]);
      alu_seq #(.EXEC_CYC(g == 0 ? 1 : 3)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_a      (in_a[g]),
         .in_b      (in_b[g]),
         .in_sel    (in_sel[g]),
`ifdef ALU_SEQ_ACC_EN
         .in_use_acc(use_acc[g]),
`endif
         .alu_a     (alu_a[g]),
         .alu_b     (alu_b[g]),
         .alu_sel   (alu_sel[g]),
         .alu_out   (alu_out[g]),
         .alu_v     (alu_v[g]),
         .alu_c     (alu_c[g]),
         .res_valid (res_valid[g]),
         .res_ready (res_ready[g]),
         .res_data  (res_data[g]),
         .res_v     (res_v[g]),
         .res_c     (res_c[g]),
         .busy      (busy[g])
      );
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: an 8-bit add computed with plain integer arithmetic
   function automatic exp_t ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
      exp_t r;
      int   u, sg;
      u   = int'(a) + int'(b);
      sg  = int'($signed(a)) + int'($signed(b));
      r.a = a;
      r.b = b;
      r.s = s;
      r.d = 8'(u);
      r.c = (u > 255);
      r.v = (sg > 127) || (sg < -128);
      return r;
   endfunction

   // Monitor: checks operand stability, result values, latency and hold-while-stalled
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst_n) begin
            chk($sformatf("ready_vs_busy[%0d]", k), in_ready[k], !busy[k]);
            if (in_valid[k] && in_ready[k]) acc_t[k] = cyc;
            if (busy[k] && !res_valid[k] && sb[k].size() != 0) begin
               chk($sformatf("alu_a[%0d]", k), alu_a[k], sb[k][0].a);
               chk($sformatf("alu_b[%0d]", k), alu_b[k], sb[k][0].b);
               chk($sformatf("alu_sel[%0d]", k), alu_sel[k], sb[k][0].s);
            end
            if (res_valid[k] && !was_v[k]) begin
               if (sb[k].size() == 0) chk($sformatf("unexpected_result[%0d]", k), sb[k].size(), 1);
               else begin
                  e = sb[k].pop_front();
                  chk($sformatf("res_data[%0d]", k), res_data[k], e.d);
                  chk($sformatf("res_v[%0d]", k), res_v[k], e.v);
                  chk($sformatf("res_c[%0d]", k), res_c[k], e.c);
                  chk($sformatf("latency[%0d]", k), cyc - acc_t[k], ec[k] + 1);
               end
               held_d[k] = res_data[k];
               held_v[k] = res_v[k];
               held_c[k] = res_c[k];
            end else if (res_valid[k]) begin
               chk($sformatf("hold_data[%0d]", k), res_data[k], held_d[k]);
               chk($sformatf("hold_v[%0d]", k), res_v[k], held_v[k]);
               chk($sformatf("hold_c[%0d]", k), res_c[k], held_c[k]);
            end
            was_v[k] = res_valid[k];
         end else was_v[k] = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation on instance k, keep res_ready low for hold cycles in DONE, then consume
   task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                     input logic acc, input int hold);
      exp_t e;
      int   t;
      t = 0;
      while (!in_ready[k] && t < 50) begin
         step();
         t++;
      end
      chk($sformatf("wait_ready[%0d]", k), in_ready[k], 1);
`ifdef ALU_SEQ_ACC_EN
      use_acc[k] = acc;
`else
      acc = 1'b0;
`endif
      e = ref_op(acc ? acc_m[k] : a, b, s);
      sb[k].push_back(e);
      acc_m[k]     = e.d;
      in_valid[k]  = 1'b1;
      in_a[k]      = a;
      in_b[k]      = b;
      in_sel[k]    = s;
      res_ready[k] = 1'($urandom);
      step();
      t = 0;
      while (t < 60) begin
         if (res_valid[k] && hold <= 0) break;
         if (res_valid[k]) hold--;
         in_valid[k]  = 1'($urandom);
         in_a[k]      = 8'($urandom);
         in_b[k]      = 8'($urandom);
         in_sel[k]    = 2'($urandom);
`ifdef ALU_SEQ_ACC_EN
         use_acc[k]   = 1'($urandom);
`endif
         res_ready[k] = res_valid[k] ? 1'b0 : 1'($urandom);
         step();
         t++;
      end
      chk($sformatf("result_timeout[%0d]", k), res_valid[k], 1);
      in_valid[k]  = 1'b0;
      res_ready[k] = 1'b1;
      step();
      res_ready[k] = 1'b0;
      chk($sformatf("valid_drop[%0d]", k), res_valid[k], 0);
      chk($sformatf("ready_back[%0d]", k), in_ready[k], 1);
   endtask

   task automatic chk_reset_outputs();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_alu_a[%0d]", k), alu_a[k], 0);
         chk($sformatf("rst_alu_b[%0d]", k), alu_b[k], 0);
         chk($sformatf("rst_alu_sel[%0d]", k), alu_sel[k], 0);
         chk($sformatf("rst_res_valid[%0d]", k), res_valid[k], 0);
         chk($sformatf("rst_res_data[%0d]", k), res_data[k], 0);
         chk($sformatf("rst_res_vc[%0d]", k), {res_v[k], res_c[k]}, 0);
         chk($sformatf("rst_busy[%0d]", k), busy[k], 0);
         chk($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         in_valid[k]  = 1'b1;
         in_a[k]      = 8'h12;
         in_b[k]      = 8'h34;
         in_sel[k]    = 2'd1;
         res_ready[k] = 1'b0;
         acc_m[k]     = 8'h00;
         acc_t[k]     = 0;
         was_v[k]     = 1'b0;
`ifdef ALU_SEQ_ACC_EN
         use_acc[k]   = 1'b0;
`endif
      end
      repeat (3) step();
      chk_reset_outputs();
      for (int k = 0; k < 2; k++) in_valid[k] = 1'b0;
      rst_n = 1'b1;
      step();
      chk("no_accept_after_reset", busy[0] | busy[1], 0);
      op(0, 8'h7F, 8'h01, 2'd0, 1'b0, 0);
      op(0, 8'hFF, 8'h01, 2'd2, 1'b0, 5);
      op(1, 8'h11, 8'h22, 2'd3, 1'b0, 0);
      op(1, 8'h80, 8'h80, 2'd1, 1'b0, 2);
`ifdef ALU_SEQ_ACC_EN
      op(0, 8'h10, 8'h20, 2'd0, 1'b0, 0);
      op(0, 8'hAA, 8'h05, 2'd0, 1'b1, 0);
      chk("acc_chain", res_data[0], 8'h35);
`endif
      in_valid[1] = 1'b1;
      in_a[1]     = 8'h40;
      in_b[1]     = 8'h41;
      step();
      in_valid[1] = 1'b0;
      step();
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) acc_m[k] = 8'h00;
      #1;
      chk_reset_outputs();
      step();
      rst_n = 1'b1;
      repeat (8) step();
      chk("no_valid_after_abort", res_valid[1], 0);
      op(1, 8'h05, 8'h03, 2'd0, 1'b0, 1);
      chk("after_abort_data", res_data[1], 8'h08);
      for (int i = 0; i < 40; i++)
         op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2'($urandom),
            1'($urandom), int'($urandom_range(0, 3)));
      repeat (4) step();
      for (int k = 0; k < 2; k++) chk($sformatf("scoreboard_empty[%0d]", k), sb[k].size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
